// File: rtl/oam_dma_controller.sv
`timescale 1ns/1ps
// OAM DMA sequencer: copies XFER_LEN bytes from {src,8'h00} into OAM on the shared
// memory bus, stalling the CPU and muxing address/OE/WE while it owns the bus.
module oam_dma_controller #(
  parameter int unsigned XFER_LEN     = 160,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_start,
  input  logic [7:0]  dma_src,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_OE,
  input  logic        cpu_WE,
  output logic [15:0] mem_addr,
  output logic        mem_OE,
  output logic        mem_WE,
  inout  logic [7:0]  databus,
  output logic        cpu_wait,
  output logic        dma_active,
  output logic        dma_done
);

  localparam int unsigned IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam int unsigned SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(XFER_LEN - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   setup_cnt;
  logic [7:0]      src_q;
  logic [7:0]      data_q;
  logic [7:0]      src_eff;
  logic [7:0]      idx_lo;

  // Echo RAM (0xE000-0xFDFF) mirrors work RAM at 0xC000-0xDDFF.
  assign src_eff = (src_q < 8'hE0) ? src_q : (src_q - 8'h20);
  assign idx_lo  = 8'(idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      setup_cnt <= '0;
      src_q     <= '0;
      data_q    <= '0;
      dma_done  <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      // A start in any state (re)arms the copy; an in-flight WRITE still lands this edge.
      if (dma_start) begin
        state     <= S_SETUP;
        idx       <= '0;
        setup_cnt <= '0;
        src_q     <= dma_src;
      end else begin
        case (state)
          S_IDLE: ;
          S_SETUP: begin
            if (setup_cnt == SETUP_LAST) state <= S_READ;
            else                         setup_cnt <= setup_cnt + SW'(1);
          end
          S_READ: begin
            data_q <= databus;
            state  <= S_WRITE;
          end
          S_WRITE: begin
            if (idx == LAST_IDX) begin
              state    <= S_IDLE;
              dma_done <= 1'b1;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_READ;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_addr   = cpu_addr;
    mem_OE     = cpu_OE;
    mem_WE     = cpu_WE;
    dma_active = 1'b0;
    case (state)
      S_READ: begin
        mem_addr   = {src_eff, idx_lo};
        mem_OE     = 1'b1;
        mem_WE     = 1'b0;
        dma_active = 1'b1;
      end
      S_WRITE: begin
        mem_addr   = DEST_BASE + 16'(idx);
        mem_OE     = 1'b0;
        mem_WE     = 1'b1;
        dma_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_wait = dma_active;
  assign databus  = (state == S_WRITE) ? data_q : 'z;

endmodule

// File: tb/tb_oam_dma_controller.sv
`timescale 1ns/1ps
// Bench for oam_dma_controller: byte-wide memory model on the shared bus, write
// scoreboard, IDLE pass-through vector table and multi-cycle transfer scenarios.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_src = '0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_OE = 1'b0;
  logic        cpu_WE = 1'b0;
  wire  [15:0] mem_addr;
  wire         mem_OE, mem_WE, cpu_wait, dma_active, dma_done;
  wire  [7:0]  databus;

  oam_dma_controller #(.XFER_LEN(160), .DEST_BASE(16'hFE00), .SETUP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_src(dma_src),
    .cpu_addr(cpu_addr), .cpu_OE(cpu_OE), .cpu_WE(cpu_WE),
    .mem_addr(mem_addr), .mem_OE(mem_OE), .mem_WE(mem_WE), .databus(databus),
    .cpu_wait(cpu_wait), .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign databus = (mem_OE && !mem_WE) ? mem[mem_addr] : 'z;
  always @(posedge clk) if (mem_WE) mem[mem_addr] <= databus;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wait_cnt = 0;
  logic [23:0] sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (dma_done) begin done_cnt++; done_cyc = cyc; end
    if (cpu_wait) wait_cnt++;
    if (rst && dma_active && mem_WE) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected_write: got %h:%h expected none", mem_addr, databus);
      end else begin
        e = sbq.pop_front();
        check("sb_write", {8'h0, mem_addr, databus}, {8'h0, e});
      end
    end
  end

  function automatic logic [7:0] eff(input logic [7:0] s);
    return (s < 8'hE0) ? s : s - 8'h20;
  endfunction

  task automatic push_expected(input logic [7:0] src);
    logic [15:0] a;
    sbq.delete();
    for (int i = 0; i < 160; i++) begin
      a = 16'hFE00 + 16'(i);
      sbq.push_back({a, mem[{eff(src), 8'(i)}]});
    end
  endtask

  task automatic finish_start(input logic [7:0] src);
    @(posedge clk); #1;
    dma_start = 1'b0;
    start_cyc = cyc;
    push_expected(src);
  endtask

  task automatic start_dma(input logic [7:0] src);
    @(posedge clk); #1;
    dma_start = 1'b1;
    dma_src   = src;
    finish_start(src);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_latency"}, done_cyc - start_cyc, 321);
    check({name, "_sb_empty"}, sbq.size(), 0);
  endtask

  task automatic check_oam(input string name, input logic [7:0] src);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== mem[{eff(src), 8'(i)}]) bad++;
    check(name, bad, 0);
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'h00;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        oe;
    logic        we;
    logic [15:0] exp_addr;
    logic        exp_oe;
    logic        exp_we;
    logic        exp_wait;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + 16'(i)] = 8'(i * 7 + 3);
    end

    // Reset state
    cpu_addr = 16'h1234; cpu_OE = 1'b1;
    #1;
    check("rst_active", dma_active, 0);
    check("rst_wait", cpu_wait, 0);
    check("rst_done", dma_done, 0);
    check("rst_addr_pass", mem_addr, 16'h1234);
    check("rst_oe_pass", mem_OE, 1);
    #20 rst = 1'b1;

    // IDLE pass-through vectors
    vecs[0] = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h8001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'hFF46, 1'b0, 1'b0, 16'hFF46, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'hA5A5, 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      cpu_addr = vecs[v].addr; cpu_OE = vecs[v].oe; cpu_WE = vecs[v].we;
      #1;
      check("vec_addr", mem_addr, vecs[v].exp_addr);
      check("vec_oe", mem_OE, vecs[v].exp_oe);
      check("vec_we", mem_WE, vecs[v].exp_we);
      check("vec_wait", cpu_wait, vecs[v].exp_wait);
    end

    // Basic copy with CPU blocked during the transfer
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_OE = 1'b1; cpu_WE = 1'b0;
    clear_oam(); done_cnt = 0; wait_cnt = 0;
    start_dma(8'hC0);
    check("setup_pass_addr", mem_addr, 16'h1234);
    check("setup_wait", cpu_wait, 0);
    @(posedge clk); #1;
    check("read0_addr", mem_addr, 16'hC000);
    check("read0_oe", mem_OE, 1);
    check("read0_we", mem_WE, 0);
    check("read0_wait", cpu_wait, 1);
    cpu_addr = 16'hC000; cpu_OE = 1'b0; cpu_WE = 1'b1;
    @(posedge clk); #1;
    check("write0_addr", mem_addr, 16'hFE00);
    check("write0_we", mem_WE, 1);
    check("write0_oe", mem_OE, 0);
    repeat (100) @(posedge clk);
    #1 cpu_WE = 1'b0; cpu_addr = 16'h1234;
    wait_done("basic");
    check_oam("basic_oam", 8'hC0);
    check("basic_wait_cycles", wait_cnt, 320);
    check("basic_c000_kept", mem[16'hC000], 8'h5A);

    // Echo source
    clear_oam(); done_cnt = 0;
    start_dma(8'hE1);
    wait_done("echo");
    check_oam("echo_oam", 8'hC1);

    // Restart mid-transfer
    clear_oam(); done_cnt = 0;
    start_dma(8'hC0);
    repeat (50) @(posedge clk);
    start_dma(8'hC1);
    wait_done("restart");
    check_oam("restart_oam", 8'hC1);

    // Restart coincident with the final WRITE
    clear_oam(); done_cnt = 0;
    start_dma(8'hC0);
    begin
      int n;
      n = 0;
      do begin @(posedge clk); #1; n++; end
      while (!(dma_active && mem_WE && mem_addr == 16'hFE9F) && n < 400);
      check("coll_reach_last", {15'h0, dma_active, mem_addr}, {15'h0, 1'b1, 16'hFE9F});
    end
    dma_start = 1'b1; dma_src = 8'hC1;
    @(posedge clk); #1;
    dma_start = 1'b0; start_cyc = cyc;
    check("coll_old_sb_empty", sbq.size(), 0);
    check("coll_no_done", dma_done, 0);
    push_expected(8'hC1);
    wait_done("coll");
    check_oam("coll_oam", 8'hC1);

    // Asynchronous reset mid-transfer
    done_cnt = 0;
    cpu_addr = 16'h2345; cpu_OE = 1'b1; cpu_WE = 1'b0;
    start_dma(8'hC0);
    repeat (99) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_active", dma_active, 0);
    check("arst_wait", cpu_wait, 0);
    check("arst_addr", mem_addr, 16'h2345);
    check("arst_oe", mem_OE, 1);
    check("arst_we", mem_WE, 0);
    sbq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, 0);
    check("arst_idle", dma_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences OAM DMA on the shared memory-unit bus. A CPU write to 0xFF46 (DMA register) starts a copy of XFER_LEN bytes from {src,8'h00} to DEST_BASE.
- Sits between the CPU bus master and the memoryunit. Muxes address/OE/WE, stalls the CPU while it owns the bus, and drives databus only during its own write cycles.

Parameters:
- XFER_LEN, 160, bytes per transfer (index width = $clog2(XFER_LEN)).
- DEST_BASE, 16'hFE00, first destination address (OAM).
- SETUP_CYCLES, 1, cycles between start and first DMA read; CPU keeps the bus during these cycles.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- dma_start  input  1  one-cycle pulse, asserted when the CPU writes address 0xFF46.
- dma_src  input  8  source high byte, sampled when dma_start=1.
- cpu_addr  input  16  CPU bus address.
- cpu_OE  input  1  CPU read enable.
- cpu_WE  input  1  CPU write enable.
- mem_addr  output  16  address to memoryunit.
- mem_OE  output  1  OE to memoryunit.
- mem_WE  output  1  WE to memoryunit.
- databus  inout  8  shared data bus; driven only in WRITE state, else 8'bz.
- cpu_wait  output  1  CPU must hold its current access while this is high.
- dma_active  output  1  DMA owns the bus (READ/WRITE states).
- dma_done  output  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, src_q=0, data_q=0, cpu_wait=0, dma_active=0, dma_done=0, databus released. Bus outputs pass the CPU through.
- States: IDLE, SETUP, READ, WRITE.
- IDLE: mem_* = cpu_*. On dma_start: src_q<=dma_src, idx<=0, go to SETUP.
- SETUP: CPU still passes through, cpu_wait=0. A counter runs SETUP_CYCLES cycles, then the state goes to READ.
- READ:
  - mem_addr = {src_eff, idx[7:0]}, mem_OE=1, mem_WE=0.
  - data_q <= databus at posedge; state goes to WRITE.
- WRITE:
  - mem_addr = DEST_BASE + idx, mem_WE=1, mem_OE=0, databus = data_q.
  - At posedge: if idx==XFER_LEN-1, go to IDLE and pulse dma_done next cycle. Otherwise idx<=idx+1 and go to READ.
- src_eff: src_q when src_q < 8'hE0; otherwise src_q - 8'h20 (echo region mapped onto 0xC000–0xDFFF).
- Ownership: dma_active=1 and cpu_wait=1 in READ/WRITE. The CPU's cpu_OE/cpu_WE never reach the memoryunit while dma_active=1.
- Timing:
  - Each byte costs 2 cycles; a full transfer is SETUP_CYCLES + 2*XFER_LEN cycles (321 by default) from the cycle after the dma_start edge.
  - dma_done is high in the first IDLE cycle after the final WRITE.
- Restart: dma_start in SETUP/READ/WRITE aborts the current copy. Next state=SETUP, idx<=0, src_q<=dma_src. Any in-progress WRITE cycle still completes its write at that edge.
- Simultaneous events:
  - dma_start on the final WRITE edge: restart wins; no dma_done pulse.
  - cpu_WE to 0xFF46 while DMA is active is blocked by cpu_wait. Only an external dma_start causes a restart.
- Reset mid-transfer: immediate return to IDLE with the bus released. Partially written OAM is left as-is.
- databus is never driven by this block outside WRITE; there is no contention with SRAM_BANK reads.
- idx never exceeds XFER_LEN-1; there is no wrap into 0xFEA0+.

Test Plan:
- Basic copy: preload 0xC000–0xC09F with i^8'h5A; pulse dma_start, dma_src=8'hC0 -> after 321 cycles, OAM 0xFE00+i == i^8'h5A for i=0..159; dma_done pulses exactly once; cpu_wait high for exactly 320 cycles.
- Bus mux: during transfer, drive cpu_addr=16'hC000, cpu_WE=1 -> C000 is unchanged. The first READ cycle shows mem_addr=16'hC000 (DMA index 0); the first WRITE cycle shows mem_addr=16'hFE00, mem_WE=1.
- Echo source: dma_src=8'hE1 -> reads come from 0xC100–0xC19F; OAM matches that data.
- Restart: dma_src=8'hC0, then after 50 cycles dma_start with dma_src=8'hC1 -> idx restarts at 0; final OAM equals 0xC100–0xC19F; one dma_done, 321 cycles after the second start.
- Async reset: assert rst=0 at cycle 100 of a transfer -> same-cycle outputs are state=IDLE, cpu_wait=0, databus=z, mem_* = cpu_*. No dma_done after release.
- Final-edge collision: dma_start coincident with the WRITE of idx 159 -> no dma_done; a new 321-cycle transfer runs.
